// File: rtl/data_mem_sized.sv
// data_mem_sized
//   Sized load/store data memory of DEPTH 64-bit words with a fixed response
//   latency. The memory uses little-endian byte lanes. A request is captured
//   when req_valid and req_ready are both high. The access completes LATENCY
//   rising edges later and is reported with a one-cycle rsp_valid pulse.
//   Loads are sign- or zero-extended to 64 bits. A store updates only the
//   byte lanes that its size and offset select.
//
//   Every memory word is cleared by reset, so the storage is built from
//   flops and not from block RAM.
//
// Configuration macro
//   DATA_MEM_MISALIGN_TRAP_EN
//     Defined:   an access whose offset is not a multiple of its size is
//                rejected. The response has rsp_err = 1, no write takes
//                place, and read_data = 0.
//     Undefined: the offset is aligned down to the access size and the access
//                completes normally. rsp_err then flags out-of-range only.
//
// Parameters
//   ADDR_W   byte-address width
//   DEPTH    number of 64-bit words (power of two, >= 2)
//   LATENCY  rising edges from the accept edge to the response (>= 1)
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           asynchronous, active-low reset
//   req_valid     request present
//   req_ready     high only while idle
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 double
//   req_unsigned  1 = zero-extend loads, 0 = sign-extend
//   address       byte address
//   write_data    store data, LSB-aligned
//   rsp_valid     one-cycle response pulse
//   read_data     extended load result; held until the next completion
//   rsp_err       access rejected; valid with rsp_valid and held like read_data
module data_mem_sized #(
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [63:0]       write_data,
  output logic              rsp_valid,
  output logic [63:0]       read_data,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // The wait counter only ever holds values in the range 0 .. LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [63:0]       read_data_q, read_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [63:0] mem_q [DEPTH];
  logic [63:0] mem_d [DEPTH];

  // Decode of the captured request.
  logic [IDX_W-1:0] word_idx;
  logic [2:0]       offset;
  logic [2:0]       align_mask;
  logic [2:0]       eff_off;
  logic [7:0]       size_lanes;
  logic [7:0]       byte_en;
  logic [63:0]      cur_word;
  logic [63:0]      wr_shift;
  logic [63:0]      rd_shift;
  logic [63:0]      merged_word;
  logic [63:0]      load_val;
  logic             out_of_range;
  logic             reject;
  logic             mem_we;

  assign word_idx = addr_q[IDX_W+2:3];
  assign offset   = addr_q[2:0];

  // Any set bit above the last word index puts the address at or beyond
  // DEPTH*8. This covers huge addresses without a wide comparator.
  generate
    if (ADDR_W > IDX_W + 3) begin : g_range
      assign out_of_range = |addr_q[ADDR_W-1:IDX_W+3];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    case (size_q)
      2'b00:   begin align_mask = 3'b000; size_lanes = 8'h01; end
      2'b01:   begin align_mask = 3'b001; size_lanes = 8'h03; end
      2'b10:   begin align_mask = 3'b011; size_lanes = 8'h0F; end
      default: begin align_mask = 3'b111; size_lanes = 8'hFF; end
    endcase
  end

  // The aligned-down offset serves both build variants. When trapping, a
  // misaligned access is rejected before eff_off can matter.
  assign eff_off = offset & ~align_mask;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(offset & align_mask);
  assign reject     = out_of_range | misaligned;
`else
  assign reject     = out_of_range;
`endif

  assign cur_word = mem_q[word_idx];
  assign byte_en  = size_lanes << eff_off;
  assign wr_shift = wdata_q << {eff_off, 3'b000};
  assign rd_shift = cur_word >> {eff_off, 3'b000};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? wr_shift[gi*8 +: 8]
                                                  : cur_word[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    case (size_q)
      2'b00:   load_val = uns_q ? {56'd0, rd_shift[7:0]}
                                : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = uns_q ? {48'd0, rd_shift[15:0]}
                                : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   load_val = uns_q ? {32'd0, rd_shift[31:0]}
                                : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Next-state logic for the FSM, the captured request and the response regs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    read_data_d = read_data_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = address;
          wdata_d = write_data;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = reject;
          read_data_d = (reject || we_q) ? 64'd0 : load_val;
          mem_we      = we_q && !reject;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      read_data_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      read_data_q <= read_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage words. Only the addressed word takes the lane-merged value.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (mem_we && (word_idx == IDX_W'(gi))) begin
          mem_d[gi] = merged_word;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign read_data = read_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Testbench for data_mem_sized (DEPTH = 32, LATENCY = 3).
// Each expected response is pushed to a scoreboard queue on its accept edge.
// A negedge monitor pops the queue and compares it against every rsp_valid
// pulse. The expected values follow DATA_MEM_MISALIGN_TRAP_EN when the
// macro is defined.
module tb_data_mem_sized;

  localparam int LAT = 3;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam logic [63:0] LW42_DATA  = 64'd0;
  localparam logic [63:0] LW42_ERR   = 64'd1;
  localparam logic [63:0] SH45_ERR   = 64'd1;
  localparam logic [63:0] W40_FINAL  = 64'h0123BEEF80ABCDEF;
  localparam logic [63:0] LWU44_DATA = 64'h000000000123BEEF;
`else
  localparam logic [63:0] LW42_DATA  = 64'hFFFFFFFF80ABCDEF;
  localparam logic [63:0] LW42_ERR   = 64'd0;
  localparam logic [63:0] SH45_ERR   = 64'd0;
  localparam logic [63:0] W40_FINAL  = 64'h0123111180ABCDEF;
  localparam logic [63:0] LWU44_DATA = 64'h0000000001231111;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        rsp_valid;
  logic [63:0] read_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [64:0] sb_q[$];   // {rsp_err, read_data}

  always #5 clk = ~clk;

  data_mem_sized #(
    .ADDR_W (64),
    .DEPTH  (32),
    .LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .address     (address),
    .write_data  (write_data),
    .rsp_valid   (rsp_valid),
    .read_data   (read_data),
    .rsp_err     (rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one queued expectation per response pulse.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      logic [64:0] exp_e;
      check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        check("rsp_read_data", read_data, exp_e[63:0]);
        check("rsp_err", 64'(rsp_err), 64'(exp_e[64]));
        $display("rsp: read_data=%h rsp_err=%0b", read_data, rsp_err);
      end
    end
  end

  task automatic scramble_inputs();
    req_valid    = 1'b0;
    req_we       = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    address      = {32'($urandom), 32'($urandom)};
    write_data   = {32'($urandom), 32'($urandom)};
  endtask

  // One complete transaction. It checks ready, the response latency and
  // that the response pulse is one cycle wide.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    address      = addr;
    write_data   = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    sb_q.push_back({exp_err, exp_rd});
    $display("req %s: we=%0b size=%0d uns=%0b addr=%h wd=%h", tag, we, sz, uns, addr, wd);
    #1 scramble_inputs();
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (rsp_valid !== 1'b1 && n < 20);
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    @(posedge clk);
    #1 check({tag, "_pulse_width"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b0;
    scramble_inputs();
    #1;
    check("rst_async_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_async_read_data", read_data, 64'd0);
    check("rst_async_rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("ready_after_reset", 64'(req_ready), 64'd1);

    // Basic double store/load, then byte lanes and extension.
    do_req("ld_d40_init", 1'b0, 2'b11, 1'b0, 64'd40, 64'd0, 64'd0, 1'b0);
    do_req("st_d40", 1'b1, 2'b11, 1'b0, 64'd40, 64'h0123456789ABCDEF, 64'd0, 1'b0);
    do_req("ld_d40", 1'b0, 2'b11, 1'b0, 64'd40, 64'd0, 64'h0123456789ABCDEF, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_read_data", read_data, 64'h0123456789ABCDEF);
    do_req("st_b43", 1'b1, 2'b00, 1'b0, 64'd43, 64'h1122334455667780, 64'd0, 1'b0);
    do_req("ld_bs43", 1'b0, 2'b00, 1'b0, 64'd43, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0);
    do_req("ld_bu43", 1'b0, 2'b00, 1'b1, 64'd43, 64'd0, 64'h0000000000000080, 1'b0);
    do_req("ld_d40_b", 1'b0, 2'b11, 1'b0, 64'd40, 64'd0, 64'h0123456780ABCDEF, 1'b0);

    // Half-word lanes.
    do_req("st_h44", 1'b1, 2'b01, 1'b0, 64'd44, 64'hFFFFFFFFFFFFBEEF, 64'd0, 1'b0);
    do_req("ld_hs44", 1'b0, 2'b01, 1'b0, 64'd44, 64'd0, 64'hFFFFFFFFFFFFBEEF, 1'b0);
    do_req("ld_hu46", 1'b0, 2'b01, 1'b1, 64'd46, 64'd0, 64'h0000000000000123, 1'b0);

    // Out-of-range accesses must leave words 31 and 0 untouched.
    do_req("st_d248", 1'b1, 2'b11, 1'b0, 64'd248, 64'hA5A5A5A5A5A5A5A5, 64'd0, 1'b0);
    do_req("st_d256_oor", 1'b1, 2'b11, 1'b0, 64'd256, 64'h0000000000000BAD, 64'd0, 1'b1);
    do_req("ld_d248", 1'b0, 2'b11, 1'b0, 64'd248, 64'd0, 64'hA5A5A5A5A5A5A5A5, 1'b0);
    do_req("ld_d_top_oor", 1'b0, 2'b11, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1'b1);
    do_req("ld_d0", 1'b0, 2'b11, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);

    // Misaligned accesses: trapped or aligned down depending on the build.
    do_req("ld_ws42", 1'b0, 2'b10, 1'b0, 64'd42, 64'd0, LW42_DATA, LW42_ERR[0]);
    do_req("st_h45", 1'b1, 2'b01, 1'b0, 64'd45, 64'h0000000000001111, 64'd0, SH45_ERR[0]);
    do_req("ld_wu44", 1'b0, 2'b10, 1'b1, 64'd44, 64'd0, LWU44_DATA, 1'b0);
    do_req("ld_d40_c", 1'b0, 2'b11, 1'b0, 64'd40, 64'd0, W40_FINAL, 1'b0);

    // req_valid held high across BUSY/RESP: the second request waits for IDLE.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; address = 64'd40;
    write_data = 64'd0; req_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back({1'b0, W40_FINAL});
    $display("req b2b_a: load double addr=40");
    #1;
    req_size = 2'b00; req_unsigned = 1'b1; address = 64'd43;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("b2b_ready", 64'(req_ready), 64'(k == 4));
      check("b2b_rsp_valid_a", 64'(rsp_valid), 64'(k == LAT));
    end
    @(posedge clk);
    sb_q.push_back({1'b0, 64'h0000000000000080});
    $display("req b2b_b: load byte unsigned addr=43");
    #1 scramble_inputs();
    check("b2b_ready_after_b", 64'(req_ready), 64'd0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk);
      #1 check("b2b_rsp_valid_b", 64'(rsp_valid), 64'(k == LAT));
    end

    // Reset during an in-flight store aborts it with no response.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0; address = 64'd0;
    write_data = 64'h55; req_valid = 1'b1;
    @(posedge clk);
    $display("req abort: store double 0x55 addr=0, reset follows");
    #1 scramble_inputs();
    check("abort_busy_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rst_read_data", read_data, 64'd0);
    check("abort_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) pulses++;
      if (k == 0) check("abort_ready_after_release", 64'(req_ready), 64'd1);
    end
    check("abort_no_response", 64'(pulses), 64'd0);
    do_req("ld_d0_after_abort", 1'b0, 2'b11, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    do_req("ld_d40_cleared", 1'b0, 2'b11, 1'b0, 64'd40, 64'd0, 64'd0, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: byte-address width.
REQ-002 SHALL have parameter DEPTH, default 32: number of 64-bit words, power of two, >=2.
REQ-003 SHALL have parameter LATENCY, default 1: edges from accept to response, >=1.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1: request present.
REQ-007 SHALL have port req_ready  output  1: block can accept a request.
REQ-008 SHALL have port req_we  input  1: 1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2: 00 byte, 01 half, 10 word, 11 double.
REQ-010 SHALL have port req_unsigned  input  1: zero-extend loads when 1, sign-extend when 0.
REQ-011 SHALL have port address  input  ADDR_W: byte address, little-endian lanes.
REQ-012 SHALL have port write_data  input  64: store data, LSB-aligned.
REQ-013 SHALL have port rsp_valid  output  1: one-cycle response pulse.
REQ-014 SHALL have port read_data  output  64: extended load result.
REQ-015 SHALL have port rsp_err  output  1: access rejected; valid with rsp_valid.

Function
REQ-016 SHALL implement states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept on an edge where req_valid & req_ready, capturing req_we, req_size, req_unsigned, address, write_data; input changes after accept are ignored.
REQ-018 SHALL on accept go to BUSY with wait counter = LATENCY-1; in BUSY decrement each edge; at counter 0 perform the access and go to RESP.
REQ-019 SHALL assert rsp_valid for exactly the one cycle in RESP, beginning LATENCY edges after the accept edge; RESP -> IDLE on the next edge.
REQ-020 SHALL hold read_data and rsp_err stable from RESP until the next access completes.
REQ-021 SHALL select word index address[log2(DEPTH)+2:3] and lane offset address[2:0].
REQ-022 SHALL treat address >= DEPTH*8 as out of range: rsp_err = 1, no write, read_data = 0.
REQ-023 SHALL on a store update only the 1/2/4/8 byte lanes selected by size and offset; all other bytes unchanged.
REQ-024 SHALL on a load extract the selected lanes and sign- or zero-extend per req_unsigned; req_unsigned is ignored for doubles.
REQ-025 SHALL on a store drive read_data = 0 and rsp_err = 0 for an in-range access.

Reset
REQ-026 SHALL on rst low, immediately and regardless of clk: state IDLE, counter 0, rsp_valid 0, rsp_err 0, read_data 0, every memory word 0.
REQ-027 SHALL abort any in-flight access on reset; a pending store is not written and no response is produced.
REQ-028 SHALL drive req_ready = 1 from the first cycle after rst returns high.

Configuration
REQ-029 SHALL, with DATA_MEM_MISALIGN_TRAP_EN defined, reject any access whose offset is not a multiple of its size: rsp_err = 1, no write, read_data = 0.
REQ-030 SHALL, without DATA_MEM_MISALIGN_TRAP_EN, force offset low bits to zero (align down) and complete normally; rsp_err then flags out-of-range only.

Verification
REQ-031 SHALL cover store double 0x0123456789ABCDEF at 40, then load double at 40 -> read_data 0x0123456789ABCDEF, rsp_err 0, rsp_valid exactly LATENCY edges after each accept, one cycle wide.
REQ-032 SHALL cover store byte 0x80 at 43, then signed load byte at 43 -> 0xFFFFFFFFFFFFFF80, unsigned load byte -> 0x80, load double at 40 -> 0x0123456780ABCDEF.
REQ-033 SHALL cover load double at 0xFFFFFFFFFFFFFFF8 and store at 256 (DEPTH=32) -> rsp_err 1, read_data 0, word 31 unchanged.
REQ-034 SHALL cover signed load word at 42 -> with macro: rsp_err 1, read_data 0; without: rsp_err 0, read_data 0xFFFFFFFF80ABCDEF.
REQ-035 SHALL cover LATENCY=3, store double 0x55 at 0, rst pulsed low one cycle after accept -> no rsp_valid, req_ready 1 after release, load double at 0 -> 0.
REQ-036 SHALL cover req_valid held high through BUSY/RESP -> req_ready 0 there, second request accepted only on the first IDLE edge, one response per accept.
